// File: rtl/binary_to_bcd_pkg.sv
// Shared constants and elaboration-time helpers for the binary-to-BCD converter.
package binary_to_bcd_pkg;

  localparam int DIGIT_W     = 4;
  localparam int ADD3_THRESH = 5;

  // Number of decimal digits needed to represent 2^bin_w - 1 (at least one).
  function automatic int full_digits(input int bin_w);
    logic [63:0] v;
    int          n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n++;
        v = v / 64'd10;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/binary_to_bcd_dd.sv
// Purely combinational double-dabble core: one add-3/shift stage per input bit.
module binary_to_bcd_dd
  import binary_to_bcd_pkg::*;
#(
  parameter int BIN_W       = 4,
  parameter int FULL_DIGITS = 2
) (
  input  logic [BIN_W-1:0]               bin_num,
  output logic [DIGIT_W*FULL_DIGITS-1:0] bcd_full
);

  localparam int ACC_W = DIGIT_W * FULL_DIGITS;

  logic [ACC_W-1:0] stage [BIN_W+1];

  assign stage[0] = '0;

  genvar gi, gj;
  generate
    for (gi = 0; gi < BIN_W; gi++) begin : g_step
      logic [ACC_W-1:0] adj;
      for (gj = 0; gj < FULL_DIGITS; gj++) begin : g_dig
        assign adj[DIGIT_W*gj +: DIGIT_W] =
          (stage[gi][DIGIT_W*gj +: DIGIT_W] >= DIGIT_W'(ADD3_THRESH))
            ? stage[gi][DIGIT_W*gj +: DIGIT_W] + 4'd3
            : stage[gi][DIGIT_W*gj +: DIGIT_W];
      end
      // The accumulator is sized for the full input range, so the bit
      // shifted out of the top is always zero and can be dropped.
      assign stage[gi+1] = ACC_W'({adj, bin_num[BIN_W-1-gi]});
    end
  endgenerate

  assign bcd_full = stage[BIN_W];

endmodule

// File: rtl/binary_to_bcd.sv
// Registered binary-to-BCD converter, one cycle latency.
// Optional ovf output enabled by defining BINARY_TO_BCD_OVF_EN.
module binary_to_bcd
  import binary_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 4,
  parameter int DIGITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [BIN_W-1:0]          bin_num,
  output logic                      out_valid,
  output logic [DIGIT_W*DIGITS-1:0] bcd
`ifdef BINARY_TO_BCD_OVF_EN
  ,
  output logic                      ovf
`endif
);

  // Core is at least DIGITS wide so truncation never needs zero padding.
  localparam int FD = (full_digits(BIN_W) > DIGITS) ? full_digits(BIN_W) : DIGITS;

  logic [DIGIT_W*FD-1:0]     acc_full;
  logic [DIGIT_W*DIGITS-1:0] bcd_q, bcd_d;
  logic                      out_valid_q;
  logic                      unused_acc;

  binary_to_bcd_dd #(
    .BIN_W      (BIN_W),
    .FULL_DIGITS(FD)
  ) u_dd (
    .bin_num (bin_num),
    .bcd_full(acc_full)
  );

  assign unused_acc = ^acc_full;
  assign bcd_d      = in_valid ? acc_full[DIGIT_W*DIGITS-1:0] : bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bcd_q       <= bcd_d;
      out_valid_q <= in_valid;
    end
  end

  assign bcd       = bcd_q;
  assign out_valid = out_valid_q;

`ifdef BINARY_TO_BCD_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = in_valid ? (64'(bin_num) >= pow10(DIGITS)) : ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench driving four converter configurations from one shared stimulus.
module tb_binary_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] bin;

  logic        ov_a, ov_b, ov_c, ov_d;
  logic [3:0]  bcd_a;
  logic [7:0]  bcd_b;
  logic [11:0] bcd_c;
  logic [15:0] bcd_d;
`ifdef BINARY_TO_BCD_OVF_EN
  logic        ovf_a, ovf_b, ovf_c, ovf_d;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  b;
    logic [11:0] c;
    logic [15:0] d;
    logic [3:0]  ov;
  } exp_t;

  exp_t sb[$];
  exp_t cur, last;

  always #5 clk = ~clk;

  binary_to_bcd #(.BIN_W(4), .DIGITS(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bin_num(bin[3:0]),
    .out_valid(ov_a), .bcd(bcd_a)
`ifdef BINARY_TO_BCD_OVF_EN
    , .ovf(ovf_a)
`endif
  );
  binary_to_bcd #(.BIN_W(4), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bin_num(bin[3:0]),
    .out_valid(ov_b), .bcd(bcd_b)
`ifdef BINARY_TO_BCD_OVF_EN
    , .ovf(ovf_b)
`endif
  );
  binary_to_bcd #(.BIN_W(8), .DIGITS(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bin_num(bin[7:0]),
    .out_valid(ov_c), .bcd(bcd_c)
`ifdef BINARY_TO_BCD_OVF_EN
    , .ovf(ovf_c)
`endif
  );
  binary_to_bcd #(.BIN_W(12), .DIGITS(4)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bin_num(bin),
    .out_valid(ov_d), .bcd(bcd_d)
`ifdef BINARY_TO_BCD_OVF_EN
    , .ovf(ovf_d)
`endif
  );

  // Reference: repeated division by ten, low digit first.
  function automatic logic [15:0] to_bcd(input int unsigned x, input int nd);
    logic [15:0] r;
    int unsigned v;
    r = '0;
    v = x;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input logic [11:0] v);
    exp_t e;
    e.a     = 4'(to_bcd(int'(v[3:0]), 1));
    e.b     = 8'(to_bcd(int'(v[3:0]), 2));
    e.c     = 12'(to_bcd(int'(v[7:0]), 3));
    e.d     = to_bcd(int'(v), 4);
    e.ov[0] = (v[3:0] >= 4'd10);
    e.ov[1] = 1'b0;
    e.ov[2] = 1'b0;
    e.ov[3] = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input exp_t e, input logic vld);
    chk("valid_a", 16'(ov_a), 16'(vld));
    chk("valid_b", 16'(ov_b), 16'(vld));
    chk("valid_c", 16'(ov_c), 16'(vld));
    chk("valid_d", 16'(ov_d), 16'(vld));
    chk("bcd_a", 16'(bcd_a), 16'(e.a));
    chk("bcd_b", 16'(bcd_b), 16'(e.b));
    chk("bcd_c", 16'(bcd_c), 16'(e.c));
    chk("bcd_d", bcd_d, e.d);
    for (int k = 0; k < 4; k++)
      chk("nibble_le9_d", 16'(bcd_d[4*k +: 4] <= 4'd9), 16'd1);
`ifdef BINARY_TO_BCD_OVF_EN
    chk("ovf_a", 16'(ovf_a), 16'(e.ov[0]));
    chk("ovf_b", 16'(ovf_b), 16'(e.ov[1]));
    chk("ovf_c", 16'(ovf_c), 16'(e.ov[2]));
    chk("ovf_d", 16'(ovf_d), 16'(e.ov[3]));
`endif
  endtask

  task automatic step(input logic vld, input logic [11:0] v);
    @(negedge clk);
    in_valid = vld;
    bin      = v;
    if (vld) sb.push_back(make_exp(v));
    @(posedge clk);
    #1;
    cur = last;
    if (vld && sb.size() > 0) cur = sb.pop_front();
    $display("[TB] in_valid=%0b bin=%0d bcd_a=%h bcd_b=%h bcd_c=%h bcd_d=%h",
             vld, v, bcd_a, bcd_b, bcd_c, bcd_d);
    check_all(cur, vld);
    last = cur;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    bin      = '0;
    last     = make_exp(12'd0);
    #1;
    check_all(last, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full 4-bit sweep, back-to-back.
    for (int i = 0; i < 16; i++) step(1'b1, 12'(i));

    // Directed points for the wider configurations.
    step(1'b1, 12'd15);
    step(1'b1, 12'd9);
    step(1'b1, 12'd255);
    step(1'b1, 12'd100);
    step(1'b1, 12'd0);
    step(1'b1, 12'd4095);

    // Single conversion followed by idle cycles: outputs must hold.
    step(1'b1, 12'd7);
    step(1'b0, 12'd0);
    step(1'b0, 12'd12);
    step(1'b0, 12'd5);

    // Asynchronous reset between edges while a result is showing.
    step(1'b1, 12'd9);
    #2;
    rst = 1'b1;
    #1;
    check_all(make_exp(12'd0), 1'b0);
    sb.delete();
    last = make_exp(12'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    step(1'b0, 12'd0);
    step(1'b1, 12'd3);

    // Randomized back-to-back traffic with occasional idle cycles.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 7) != 0), 12'($urandom_range(0, 4095)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
